if_stage_mo: RTL and testbench



---
 rtl/if_stage_mo_pkg.sv | 24 ++
 rtl/if_sync_fifo.sv | 44 ++++
 rtl/if_stage_mo.sv | 139 +++++++++++++
 tb/tb_if_stage_mo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_mo_pkg.sv
// Fetch-stage shared types and the FS->DS bus width.
// The bus is packed as {adef, inst[31:0], pc[31:0]}.
`ifndef FS_TO_DS_BUS_WD
`define FS_TO_DS_BUS_WD 65
`endif

package if_stage_mo_pkg;

    typedef struct packed {
        logic        adef;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_entry_t;

    function automatic fs_entry_t fs_pack(input logic adef, input logic [31:0] inst,
                                          input logic [31:0] pc);
        fs_entry_t e;
        e.adef = adef;
        e.inst = inst;
        e.pc   = pc;
        return e;
    endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// Small synchronous FIFO with a combinational head and an occupancy count.
// DEPTH need not be a power of two; pointers wrap explicitly.
module if_sync_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= nxt(wr_q);
            end
            if (pop_i) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/if_stage_mo.sv
// Multi-outstanding instruction fetch stage with an instruction queue and discard counter.
// Define IF_PERF_CNT_EN to add the fetch/discard/stall performance counter ports.
module if_stage_mo
    import if_stage_mo_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ds_allowin,
    input  logic                        flush_valid,
    input  logic [31:0]                 flush_target,
    input  logic                        br_valid,
    input  logic [31:0]                 br_target,
    input  logic                        br_stall,
    output logic                        fs_to_ds_valid,
    output logic [`FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                        inst_sram_req,
    output logic                        inst_sram_wr,
    output logic [1:0]                  inst_sram_size,
    output logic [3:0]                  inst_sram_wstrb,
    output logic [31:0]                 inst_sram_addr,
    output logic [31:0]                 inst_sram_wdata,
    input  logic                        inst_sram_addr_ok,
    input  logic                        inst_sram_data_ok,
    input  logic [31:0]                 inst_sram_rdata
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0]                 perf_fetch_cnt,
    output logic [31:0]                 perf_discard_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int QCW = $clog2(IBUF_DEPTH + 1);
    localparam int LW  = QCW + CW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          halted_q, halted_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] inflight;
    logic [QCW-1:0] q_count;
    logic [LW-1:0] live;
    logic [31:0]   pc_head, redirect_pc;
    logic          redirect, aligned, slot_ok, fire, resp, keep, adef_push, q_push, q_pop;
    fs_entry_t     q_din, q_head;

    assign redirect    = flush_valid | br_valid;
    assign redirect_pc = flush_valid ? flush_target : br_target;
    assign aligned     = fetch_pc_q[1:0] == 2'b00;

    // Every live request owns a queue slot, so a full queue can never overflow.
    assign live    = LW'(q_count) + LW'(inflight) - LW'(discard_q);
    assign slot_ok = live < LW'(IBUF_DEPTH);

    assign inst_sram_req   = ~reset & ~redirect & ~br_stall & ~halted_q & aligned
                           & (inflight < CW'(MAX_OUTSTANDING)) & slot_ok;
    assign inst_sram_addr  = fetch_pc_q;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    assign fire      = inst_sram_req & inst_sram_addr_ok;
    assign resp      = inst_sram_data_ok & (inflight != '0);
    assign keep      = resp & ~redirect & (discard_q == '0);
    assign adef_push = ~reset & ~redirect & ~halted_q & ~aligned & slot_ok;
    assign q_push    = keep | adef_push;
    assign q_din     = adef_push ? fs_pack(1'b1, 32'h0, fetch_pc_q)
                                 : fs_pack(1'b0, inst_sram_rdata, pc_head);

    assign fs_to_ds_valid = q_count != '0;
    assign q_pop          = fs_to_ds_valid & ds_allowin & ~redirect;
    assign fs_to_ds_bus   = fs_to_ds_valid ? q_head : '0;

    // The pc FIFO occupancy doubles as the in-flight request count.
    if_sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
        .clk(clk), .reset(reset), .push_i(fire), .din_i(fetch_pc_q),
        .pop_i(resp), .clear_i(1'b0), .count_o(inflight), .head_o(pc_head)
    );

    if_sync_fifo #(.WIDTH($bits(fs_entry_t)), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk(clk), .reset(reset), .push_i(q_push), .din_i(q_din),
        .pop_i(q_pop), .clear_i(redirect), .count_o(q_count), .head_o(q_head)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        discard_d  = discard_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            // All responses still owed are stale; discard_q is already part of inflight.
            discard_d  = inflight - CW'(resp);
        end else begin
            if (fire)                          fetch_pc_d = fetch_pc_q + 32'd4;
            if (adef_push)                     halted_d   = 1'b1;
            if (resp && (discard_q != '0))     discard_d  = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
            discard_q  <= discard_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_discard_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q   <= '0;
            perf_discard_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetch_q   <= perf_fetch_q + 32'(fire);
            perf_discard_q <= perf_discard_q + 32'(resp & ~keep);
            perf_stall_q   <= perf_stall_q + 32'(fs_to_ds_valid & ~ds_allowin);
        end
    end

    assign perf_fetch_cnt   = perf_fetch_q;
    assign perf_discard_cnt = perf_discard_q;
    assign perf_stall_cnt   = perf_stall_q;
`endif

    a_dok_needs_inflight: assert property (@(posedge clk) disable iff (reset)
        inst_sram_data_ok |-> (inflight != '0));

endmodule

// File: tb/tb_if_stage_mo.sv
// Directed bench for if_stage_mo with a behavioural SRAM-like bridge (fixed data latency).
module tb_if_stage_mo;
    logic        clk = 1'b0;
    logic        reset, ds_allowin, flush_valid, br_valid, br_stall;
    logic [31:0] flush_target, br_target;
    logic        fs_to_ds_valid;
    logic [`FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_discard_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    if_stage_mo dut (
        .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
        .flush_valid(flush_valid), .flush_target(flush_target),
        .br_valid(br_valid), .br_target(br_target), .br_stall(br_stall),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata)
`ifdef IF_PERF_CNT_EN
       ,.perf_fetch_cnt(perf_fetch_cnt), .perf_discard_cnt(perf_discard_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] a;
        int          rdy;
    } bq_t;

    bq_t         bq[$];
    int          cyc = 0, lat = 1, fires = 0, max_pend = 0;
    int          n_chk = 0, n_fail = 0;
    logic        req_s, dok_s;
    logic [31:0] addr_s;

    function automatic logic [64:0] ent(input logic adef, input logic [31:0] inst,
                                        input logic [31:0] pc);
        return {adef, inst, pc};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: bridge drives data_ok, pre-edge req/addr are sampled, edge, bridge bookkeeping.
    task automatic tick();
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        if (!reset && bq.size() > 0) begin
            inst_sram_rdata = ~bq[0].a;
            if (bq[0].rdy <= cyc) inst_sram_data_ok = 1'b1;
        end
        #1;
        req_s  = inst_sram_req;
        addr_s = inst_sram_addr;
        dok_s  = inst_sram_data_ok;
        @(posedge clk);
        if (reset) bq.delete();
        else begin
            if (dok_s) void'(bq.pop_front());
            if (req_s) begin
                bq.push_back('{addr_s, cyc + lat});
                fires++;
            end
        end
        if (bq.size() > max_pend) max_pend = bq.size();
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; flush_valid = 1'b0; br_valid = 1'b0; br_stall = 1'b0;
        ds_allowin = 1'b1; flush_target = 32'h0; br_target = 32'h0;
        tick(); tick();
        reset = 1'b0; fires = 0; max_pend = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!fs_to_ds_valid && n < 12) begin
            tick();
            n++;
        end
        chk(tag, fs_to_ds_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0]  pat;
        logic [31:0] exp_pc [5];
        int          got, rq;
        inst_sram_addr_ok = 1'b1;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        reset = 1'b1; ds_allowin = 1'b1; flush_valid = 1'b0; br_valid = 1'b0;
        br_stall = 1'b0; flush_target = 32'h0; br_target = 32'h0;
        @(negedge clk);

        // Reset state
        tick(); tick();
        chk("rst_req",   req_s, 1'b0);
        chk("rst_valid", fs_to_ds_valid, 1'b0);
        chk("rst_bus",   fs_to_ds_bus, 65'h0);
        chk("rst_wr",    inst_sram_wr, 1'b0);
        chk("rst_size",  inst_sram_size, 2'd2);
        reset = 1'b0;

        // Zero-wait bridge, back-to-back fetch
        lat = 1;
        tick();
        chk("t1_req0",  req_s, 1'b1);
        chk("t1_addr0", addr_s, 32'h1c000000);
        chk("t1_v0",    fs_to_ds_valid, 1'b0);
        tick();
        chk("t1_addr1", addr_s, 32'h1c000004);
        chk("t1_dok1",  dok_s, 1'b1);
        chk("t1_bus0",  fs_to_ds_bus, ent(1'b0, ~32'h1c000000, 32'h1c000000));
        tick();
        chk("t1_addr2", addr_s, 32'h1c000008);
        chk("t1_bus1",  fs_to_ds_bus, ent(1'b0, ~32'h1c000004, 32'h1c000004));
        tick();
        chk("t1_bus2",  fs_to_ds_bus, ent(1'b0, ~32'h1c000008, 32'h1c000008));

        // Longer latency: two outstanding, req pattern 1,1,0 repeating
        do_reset();
        lat = 2;
        pat = 9'b011011011;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("t2_req_c%0d", i), req_s, pat[i]);
        end
        chk("t2_fires",    fires, 6);
        chk("t2_max_pend", max_pend, 2);

        // Branch redirect with two requests in flight
        do_reset();
        lat = 3;
        tick(); tick();
        br_valid = 1'b1; br_target = 32'h1c000100;
        tick();
        chk("t3_req_redir", req_s, 1'b0);
        chk("t3_v_redir",   fs_to_ds_valid, 1'b0);
        br_valid = 1'b0;
        tick();
        chk("t3_dok_drop0", dok_s, 1'b1);
        chk("t3_req_full",  req_s, 1'b0);
        chk("t3_v_drop0",   fs_to_ds_valid, 1'b0);
        tick();
        chk("t3_dok_drop1", dok_s, 1'b1);
        chk("t3_req_tgt",   req_s, 1'b1);
        chk("t3_addr_tgt",  addr_s, 32'h1c000100);
        chk("t3_v_drop1",   fs_to_ds_valid, 1'b0);
        wait_valid("t3_wait");
        chk("t3_bus", fs_to_ds_bus, ent(1'b0, ~32'h1c000100, 32'h1c000100));

        // Flush and branch together, with a response in the same cycle
        do_reset();
        lat = 2;
        tick(); tick();
        flush_valid = 1'b1; flush_target = 32'h1c008000;
        br_valid    = 1'b1; br_target    = 32'h1c000200;
        tick();
        chk("t4_dok_same", dok_s, 1'b1);
        chk("t4_req_redir", req_s, 1'b0);
        chk("t4_v_same",   fs_to_ds_valid, 1'b0);
        flush_valid = 1'b0; br_valid = 1'b0;
        tick();
        chk("t4_req_tgt",  req_s, 1'b1);
        chk("t4_addr_tgt", addr_s, 32'h1c008000);
        chk("t4_v_drop",   fs_to_ds_valid, 1'b0);
        wait_valid("t4_wait");
        chk("t4_bus", fs_to_ds_bus, ent(1'b0, ~32'h1c008000, 32'h1c008000));

        // ID stalled for 10 cycles: exactly 4 entries buffered, then drained in order
        do_reset();
        lat = 1;
        ds_allowin = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t5_fires", fires, 4);
        chk("t5_req",   req_s, 1'b0);
        chk("t5_head",  fs_to_ds_bus, ent(1'b0, ~32'h1c000000, 32'h1c000000));
        ds_allowin = 1'b1;
        exp_pc[0] = 32'h1c000000; exp_pc[1] = 32'h1c000004; exp_pc[2] = 32'h1c000008;
        exp_pc[3] = 32'h1c00000c; exp_pc[4] = 32'h1c000010;
        got = 0;
        for (int i = 0; i < 30 && got < 5; i++) begin
            if (fs_to_ds_valid) begin
                chk($sformatf("t5_drain%0d", got), fs_to_ds_bus,
                    ent(1'b0, ~exp_pc[got], exp_pc[got]));
                got++;
            end
            tick();
        end
        chk("t5_drain_cnt", got, 5);

        // Misaligned branch target: ADEF entry, fetch halted until a flush
        do_reset();
        br_valid = 1'b1; br_target = 32'h1c000102;
        tick();
        chk("t6_req_redir", req_s, 1'b0);
        br_valid = 1'b0;
        tick();
        chk("t6_req_adef", req_s, 1'b0);
        chk("t6_valid",    fs_to_ds_valid, 1'b1);
        chk("t6_bus",      fs_to_ds_bus, ent(1'b1, 32'h0, 32'h1c000102));
        rq = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (req_s) rq++;
        end
        chk("t6_halted_req", rq, 0);
        chk("t6_v_after",    fs_to_ds_valid, 1'b0);
        flush_valid = 1'b1; flush_target = 32'h1c008000;
        tick();
        chk("t6_req_flush", req_s, 1'b0);
        flush_valid = 1'b0;
        tick();
        chk("t6_req_restart",  req_s, 1'b1);
        chk("t6_addr_restart", addr_s, 32'h1c008000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
